rsa_result_uart_tx: RTL and testbench

Serial transmitter for the encryption result path. It captures the BITS-wide RESULT word when DONE rises, then sends it over a UART line as BITS/8 bytes in 8N1 format. The MSB byte goes first; within each byte the LSB bit goes first. It sits after MEMORY and carries results off-board, complementing the operand-loading path (STIMULOUS -> MEMORY).

---
 rtl/rsa_result_uart_tx.sv | 139 +++++++++++++
 tb/tb_rsa_result_uart_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rsa_result_uart_tx.sv
// UART 8N1 transmitter for the RSA result word: captures RESULT on a DONE rising edge
// and sends it MSB byte first, LSB bit first within each byte, frames back-to-back.
module rsa_result_uart_tx #(
   parameter int BITS         = 128,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic            clock,
   input  logic            RESET_N,
   input  logic            DONE,
   input  logic [BITS-1:0] RESULT,
   output logic            tx,
   output logic            busy,
   output logic            sent,
   output logic [1:0]      dbg_state_o
);

   localparam int NBYTES = BITS / 8;
   localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
   localparam logic [BYTE_W-1:0] BYTE_ONE  = BYTE_W'(1);
   localparam logic [15:0]       BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   generate
      if ((BITS % 8) != 0 || BITS < 8) begin : g_bits_chk
         $error("rsa_result_uart_tx: BITS must be a positive multiple of 8");
      end
      if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_cpb_chk
         $error("rsa_result_uart_tx: CLKS_PER_BIT must be in 2..65535");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t            state_q;
   logic              done_q;
   logic [BITS-1:0]   shift_q;
   logic [BYTE_W-1:0] byte_cnt_q;
   logic [2:0]        bit_cnt_q;
   logic [15:0]       baud_cnt_q;
   logic              tx_q;
   logic              busy_q;
   logic              sent_q;

   logic              capture;
   logic              baud_end;
   logic [15:0]       baud_cnt_d;
   logic [2:0]        bit_cnt_d;
   logic [7:0]        cur_byte;

   // Capture needs IDLE, so a rise coinciding with the final stop edge is dropped.
   assign capture    = DONE & ~done_q & (state_q == S_IDLE);
   assign baud_end   = (baud_cnt_q == BAUD_LAST);
   assign baud_cnt_d = baud_end ? 16'd0 : baud_cnt_q + 16'd1;
   assign bit_cnt_d  = bit_cnt_q + 3'd1;
   assign cur_byte   = shift_q[BITS-1 -: 8];

   always_ff @(posedge clock or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_IDLE;
         done_q     <= 1'b0;
         shift_q    <= '0;
         byte_cnt_q <= '0;
         bit_cnt_q  <= '0;
         baud_cnt_q <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         sent_q     <= 1'b0;
      end else begin
         done_q <= DONE;
         sent_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               tx_q       <= 1'b1;
               baud_cnt_q <= '0;
               if (capture) begin
                  shift_q    <= RESULT;
                  byte_cnt_q <= BYTE_LAST;
                  bit_cnt_q  <= '0;
                  state_q    <= S_START;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_START: begin
               baud_cnt_q <= baud_cnt_d;
               if (baud_end) begin
                  state_q   <= S_DATA;
                  bit_cnt_q <= '0;
                  tx_q      <= cur_byte[0];
               end
            end
            S_DATA: begin
               baud_cnt_q <= baud_cnt_d;
               if (baud_end) begin
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_d;
                     tx_q      <= cur_byte[bit_cnt_d];
                  end
               end
            end
            S_STOP: begin
               baud_cnt_q <= baud_cnt_d;
               if (baud_end) begin
                  if (byte_cnt_q != '0) begin
                     shift_q    <= shift_q << 8;
                     byte_cnt_q <= byte_cnt_q - BYTE_ONE;
                     state_q    <= S_START;
                     tx_q       <= 1'b0;
                  end else begin
                     state_q <= S_IDLE;
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                     sent_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx          = tx_q;
   assign busy        = busy_q;
   assign sent        = sent_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rsa_result_uart_tx.sv
// Bench for rsa_result_uart_tx: a line decoder checks every received byte against
// an expected-byte queue filled at stimulus time; timing checks run alongside.
module tb_rsa_result_uart_tx;

   localparam int BITS   = 128;
   localparam int CPB    = 4;
   localparam int NB     = BITS / 8;
   localparam int TX_LEN = NB * 10 * CPB;   // 640 cycles capture edge to busy fall

   logic             clock   = 1'b0;
   logic             RESET_N = 1'b0;
   logic             DONE    = 1'b0;
   logic [BITS-1:0]  RESULT  = '0;
   logic             tx;
   logic             busy;
   logic             sent;
   logic [1:0]       dbg_state;

   logic [7:0] exp_q[$];
   int         n_cmp     = 0;
   int         n_err     = 0;
   int         rst_epoch = 0;

   rsa_result_uart_tx #(.BITS(BITS), .CLKS_PER_BIT(CPB)) dut (
      .clock      (clock),
      .RESET_N    (RESET_N),
      .DONE       (DONE),
      .RESULT     (RESULT),
      .tx         (tx),
      .busy       (busy),
      .sent       (sent),
      .dbg_state_o(dbg_state)
   );

   // clock / reset bookkeeping
   always #5 clock = ~clock;
   always @(negedge RESET_N) rst_epoch++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_bytes(input logic [BITS-1:0] val);
      for (int i = NB - 1; i >= 0; i--) exp_q.push_back(val[8*i +: 8]);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Drives one transmission; lo_at/hi_at/rst_at are cycle offsets after the capture edge (-1 = unused).
   task automatic run_tx(input logic [BITS-1:0] val, input int lo_at, input int hi_at,
                         input bit scramble, input int rst_at);
      int cyc;
      int sent_seen;
      push_bytes(val);
      RESULT = val;
      DONE   = 1'b1;
      @(posedge clock); #1;
      check("capture_tx_low", tx, 0);
      check("capture_busy", busy, 1);
      cyc       = 0;
      sent_seen = 0;
      while (busy === 1'b1 && cyc < 2 * TX_LEN) begin
         if (scramble) RESULT = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (cyc == lo_at) DONE = 1'b0;
         if (cyc == hi_at) DONE = 1'b1;
         if (cyc == rst_at) begin
            RESET_N = 1'b0;
            #1;
            check("async_rst_tx", tx, 1);
            check("async_rst_busy", busy, 0);
            check("async_rst_state", dbg_state, 0);
            return;
         end
         if (sent === 1'b1) sent_seen++;
         @(posedge clock); #1;
         cyc++;
      end
      check("tx_length", cyc, TX_LEN);
      check("sent_early", sent_seen, 0);
      check("sent_pulse", sent, 1);
      @(posedge clock); #1;
      check("sent_width", sent, 0);
      check("idle_tx_after", tx, 1);
   endtask

   task automatic watch_quiet(input string name, input int n);
      int hi;
      hi = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1;
         if (busy !== 1'b0 || tx !== 1'b1) hi++;
      end
      check(name, hi, 0);
   endtask

   // line decoder / scoreboard: samples mid-bit on falling edges
   initial begin : monitor
      logic [7:0] got;
      logic       st;
      logic       sp;
      int         ep;
      forever begin
         @(negedge clock);
         if (RESET_N === 1'b1 && tx === 1'b0) begin
            ep = rst_epoch;
            repeat (2) @(negedge clock);
            st = tx;
            for (int b = 0; b < 8; b++) begin
               repeat (CPB) @(negedge clock);
               got[b] = tx;
            end
            repeat (CPB) @(negedge clock);
            sp = tx;
            if (ep == rst_epoch && RESET_N === 1'b1) begin
               check("start_bit", st, 0);
               check("stop_bit", sp, 1);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_frame: got byte %02h, expected no frame", got);
               end else begin
                  check("frame_byte", got, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      // reset held 3 cycles
      RESET_N = 1'b0;
      DONE    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("rst_tx", tx, 1);
         check("rst_busy", busy, 0);
         check("rst_sent", sent, 0);
      end
      check("rst_state", dbg_state, 0);
      @(posedge clock); #1;
      RESET_N = 1'b1;
      watch_quiet("post_reset_quiet", 10);

      // single transfer
      run_tx(128'h0123456789ABCDEF_FEDCBA9876543210, 2, -1, 1'b0, -1);
      idle_cycles(5);

      // bit order: first byte 0x80, rest zero
      run_tx({8'h80, 120'h0}, 2, -1, 1'b0, -1);
      idle_cycles(5);

      // DONE held high for 1000 cycles: one transmission only
      run_tx(128'hA5A5_5A5A_0F0F_F0F0_C3C3_3C3C_1234_5678, -1, -1, 1'b0, -1);
      watch_quiet("held_no_retrigger", 1000 - TX_LEN - 1);
      DONE = 1'b0;
      idle_cycles(5);

      // DONE toggled mid-transfer: ignored, not queued
      run_tx(128'h1111_2222_3333_4444_5555_6666_7777_8888, 299, 300, 1'b0, -1);
      watch_quiet("mid_retrigger_ignored", 20);
      DONE = 1'b0;
      idle_cycles(5);

      // DONE rising on the same edge busy falls: ignored
      run_tx(128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_FACE_B00C, 638, 639, 1'b0, -1);
      watch_quiet("edge_retrigger_ignored", 20);
      DONE = 1'b0;
      idle_cycles(5);

      // fresh pulse after sent starts a new transfer
      run_tx(128'h00FF_00FF_00FF_00FF_00FF_00FF_00FF_00FF, 0, -1, 1'b0, -1);
      idle_cycles(5);

      // reset during data bit 4 of the third frame
      run_tx(128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 2, -1, 1'b0, 102);
      exp_q.delete();
      repeat (6) @(posedge clock);
      #1;
      check("rst_hold_tx", tx, 1);
      RESET_N = 1'b1;
      watch_quiet("post_abort_quiet", 50);
      run_tx({BITS{1'b1}}, 2, -1, 1'b0, -1);
      idle_cycles(5);

      // RESULT changing every cycle after capture
      run_tx(128'h3141_5926_5358_9793_2384_6264_3383_2795, 2, -1, 1'b1, -1);
      idle_cycles(20);

      check("leftover_expected", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
